log_kulisch_acc: RTL and testbench

Parametrised exact (Kulisch) fixed-point accumulator for log-float dot products, successor to the LogDef width package: it instantiates the accumulator those width functions size, in either tapered (posit-style) or non-tapered mode, with guard headroom, a two-stage align/add pipeline, valid/ready handshaking and a drain/readout state machine. It sits after the log-to-linear converter and before the accumulator-to-float normaliser in the dot-product unit.

---
 rtl/log_kulisch_acc.sv | 117 +++++++++++
 tb/tb_log_kulisch_acc.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/log_kulisch_acc.sv
// Exact fixed-point (Kulisch) accumulator for log-float dot products: two-stage align/add
// pipeline with valid/ready input, a drain state and a held result until the consumer takes it.
module log_kulisch_acc #(
  parameter int unsigned TAPERED = 0,
  parameter int unsigned E       = 4,
  parameter int unsigned W       = 8,
  parameter int unsigned LS      = 1,
  parameter int unsigned F       = 3,
  parameter int unsigned GUARD   = 4,
  parameter int unsigned EXP_W   = 8,
  localparam int unsigned NF     = (TAPERED != 0) ? 1 + (2 ** LS) * (W - 2) : 2 ** (E - 1),
  localparam int unsigned FR     = (TAPERED != 0) ? 2 * (2 ** LS) * (W - 2) : 2 ** E,
  localparam int unsigned ACC_W  = 1 + GUARD + NF + FR
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sign,
  input  logic [F:0]              in_mant,
  input  logic signed [EXP_W-1:0] in_exp,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ACC_W-1:0]        out_acc,
  output logic                    out_overflow
);

  typedef enum logic [1:0] {StAccum, StWait, StOut} state_e;

  state_e             state_q, state_d;
  logic               accept;
  int                 shift;
  logic [ACC_W-1:0]   mag, addend;
  logic               exp_ovf;
  logic               s1_valid_q, s1_ovf_q;
  logic [ACC_W-1:0]   s1_addend_q;
  logic [ACC_W-1:0]   acc_q, acc_d, sum;
  logic               sticky_q, sticky_d, add_ovf;

  assign in_ready = (state_q == StAccum);
  assign accept   = in_valid & in_ready;

  // Mantissa bit F lands on accumulator bit FR+in_exp; bits below the LSB are dropped
  // from the magnitude before negation so truncation is symmetric about zero.
  always_comb begin
    shift   = int'(FR) - int'(F) + int'(in_exp);
    mag     = '0;
    exp_ovf = 1'b0;
    if (int'(in_exp) > int'(NF) - 1) begin
      exp_ovf = 1'b1;
    end else if (shift >= 0) begin
      mag = ACC_W'(in_mant) << shift;
    end else begin
      mag = ACC_W'(in_mant >> (-shift));
    end
    addend = in_sign ? -mag : mag;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_ovf_q    <= 1'b0;
      s1_addend_q <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_addend_q <= addend;
        s1_ovf_q    <= exp_ovf;
      end
    end
  end

  assign sum     = acc_q + s1_addend_q;
  assign add_ovf = (acc_q[ACC_W-1] == s1_addend_q[ACC_W-1]) &&
                   (sum[ACC_W-1] != acc_q[ACC_W-1]);

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    sticky_d = sticky_q;
    if (s1_valid_q) begin
      acc_d    = sum;
      sticky_d = sticky_q | add_ovf | s1_ovf_q;
    end
    unique case (state_q)
      StAccum: if (accept && in_last) state_d = StWait;
      // The last product sits in stage 1 here and is folded in on this edge.
      StWait:  state_d = StOut;
      StOut: begin
        if (out_ready) begin
          state_d  = StAccum;
          acc_d    = '0;
          sticky_d = 1'b0;
        end
      end
      default: state_d = StAccum;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StAccum;
      acc_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      sticky_q <= sticky_d;
    end
  end

  assign out_valid    = (state_q == StOut);
  assign out_acc      = out_valid ? acc_q : '0;
  assign out_overflow = out_valid & sticky_q;

endmodule

// File: tb/tb_log_kulisch_acc.sv
// Bench for log_kulisch_acc: exact-integer reference model checked every cycle, directed
// literal cases, randomized traffic, and a tapered-mode instance.
module tb_log_kulisch_acc;

  localparam int NF      = 8;
  localparam int FR      = 16;
  localparam int F       = 3;
  localparam int ACC_W   = 29;
  localparam int FR_T    = 24;
  localparam int ACC_W_T = 42;
  localparam longint HALF = 64'sd1 <<< (ACC_W - 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              in_valid = 0, in_sign = 0, in_last = 0, out_ready = 1;
  logic [F:0]        in_mant = '0;
  logic signed [7:0] in_exp = '0;
  logic              in_ready, out_valid, out_overflow;
  logic [ACC_W-1:0]  out_acc;

  logic                t_in_valid = 0, t_in_sign = 0, t_out_ready = 1;
  logic [F:0]          t_in_mant = '0;
  logic signed [7:0]   t_in_exp = '0;
  logic                t_in_ready, t_out_valid, t_out_overflow;
  logic [ACC_W_T-1:0]  t_out_acc;

  log_kulisch_acc #(.TAPERED(0), .E(4), .W(8), .LS(1), .F(3), .GUARD(4), .EXP_W(8)) dut (
    .clock(clk), .reset(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sign(in_sign),
    .in_mant(in_mant), .in_exp(in_exp), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_acc(out_acc), .out_overflow(out_overflow)
  );

  log_kulisch_acc #(.TAPERED(1), .E(4), .W(8), .LS(1), .F(3), .GUARD(4), .EXP_W(8)) dut_t (
    .clock(clk), .reset(rst), .in_valid(t_in_valid), .in_ready(t_in_ready),
    .in_sign(t_in_sign), .in_mant(t_in_mant), .in_exp(t_in_exp), .in_last(1'b1),
    .out_valid(t_out_valid), .out_ready(t_out_ready), .out_acc(t_out_acc),
    .out_overflow(t_out_overflow)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: exact value of each product in units of 2^-FR, accumulated with
  // two's-complement wrap; 0 = accumulating, 1 = draining, 2 = result presented.
  longint m_acc = 0, m_tmp;
  bit     m_ovf = 0, m_fresh = 1;
  int     m_state = 0;

  function automatic longint prod_value(input bit s, input int m, input int e);
    longint v;
    int p;
    if (e > NF - 1 || e < -FR - F) return 0;
    p = e - F + FR;
    if (p >= 0) v = longint'(m) <<< p;
    else        v = longint'(m) >>> (-p);
    return s ? -v : v;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_acc = 0; m_ovf = 0; m_state = 0; m_fresh = 1;
    end else begin
      m_fresh = 0;
      if (m_state == 0) begin
        if (in_valid) begin
          if (int'(in_exp) > NF - 1) m_ovf = 1;
          m_tmp = m_acc + prod_value(in_sign, int'(in_mant), int'(in_exp));
          if (m_tmp >= HALF) begin m_tmp -= 2 * HALF; m_ovf = 1; end
          else if (m_tmp < -HALF) begin m_tmp += 2 * HALF; m_ovf = 1; end
          m_acc = m_tmp;
          if (in_last) m_state = 1;
        end
      end else if (m_state == 1) begin
        m_state = 2;
      end else if (out_ready) begin
        m_state = 0; m_acc = 0; m_ovf = 0; m_fresh = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("in_ready", in_ready, m_state == 0);
      check("out_valid", out_valid, m_state == 2);
      if (m_state == 2) begin
        check("out_acc", out_acc, m_acc[ACC_W-1:0]);
        check("out_overflow", out_overflow, m_ovf);
      end
      if (m_fresh) check("out_acc_cleared", out_acc, 0);
    end
  end

  task automatic send(input bit s, input int m, input int e, input bit last);
    int n = 0;
    while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
    if (!in_ready) check("send_timeout", in_ready, 1);
    in_valid = 1; in_sign = s; in_mant = (F+1)'(m); in_exp = 8'(e); in_last = last;
    @(posedge clk); #1;
    in_valid = 0; in_last = 0;
  endtask

  task automatic expect_result(input string name, input logic [127:0] acc, input bit ovf);
    int n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    check({name, "_valid"}, out_valid, 1);
    check({name, "_acc"}, out_acc, acc);
    check({name, "_ovf"}, out_overflow, ovf);
    @(posedge clk); #1;
  endtask

  task automatic tcase(input string name, input bit s, input int m, input int e,
                       input logic [127:0] acc, input bit ovf);
    int n = 0;
    while (!t_in_ready && n < 20) begin @(posedge clk); #1; n++; end
    t_in_valid = 1; t_in_sign = s; t_in_mant = (F+1)'(m); t_in_exp = 8'(e);
    @(posedge clk); #1;
    t_in_valid = 0;
    n = 0;
    while (!t_out_valid && n < 20) begin @(posedge clk); #1; n++; end
    check({name, "_valid"}, t_out_valid, 1);
    check({name, "_acc"}, t_out_acc, acc);
    check({name, "_ovf"}, t_out_overflow, ovf);
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_acc", out_acc, 0);
    check("rst_out_ovf", out_overflow, 0);
    #2 rst = 0;
    @(posedge clk); #1;
    check("rst_in_ready", in_ready, 1);

    // Single +1.0: two-cycle latency, then clear after handshake.
    send(0, 8, 0, 1);
    check("lat_in_ready_low", in_ready, 0);
    check("lat_out_valid_low", out_valid, 0);
    expect_result("one", 128'h10000, 0);
    check("hs_out_valid", out_valid, 0);
    check("hs_in_ready", in_ready, 1);
    check("hs_out_acc", out_acc, 0);

    send(0, 12, 2, 0); send(1, 8, 2, 1);
    expect_result("mixed", 128'h20000, 0);
    send(1, 8, 0, 1);
    expect_result("neg_one", 128'h1FFF0000, 0);
    send(0, 15, -16, 1);
    expect_result("tiny", 128'h1, 0);
    send(0, 15, -20, 1);
    expect_result("below", 128'h0, 0);
    send(0, 15, 7, 1);
    expect_result("top_exp", 128'hF00000, 0);
    send(0, 8, 8, 1);
    expect_result("exp_ovf", 128'h0, 1);
    send(0, 8, 0, 1);
    expect_result("ovf_cleared", 128'h10000, 0);

    // Consumer stall holds the result.
    out_ready = 0;
    send(0, 8, 1, 1);
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", out_valid, 1);
      check("stall_acc", out_acc, 128'h20000);
      check("stall_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    out_ready = 1;
    @(posedge clk); #1;
    check("stall_hs_valid", out_valid, 0);
    check("stall_hs_ready", in_ready, 1);
    check("stall_hs_acc", out_acc, 0);

    // Back-to-back products, one per cycle.
    for (int i = 0; i < 4; i++) begin
      check("b2b_ready", in_ready, 1);
      in_valid = 1; in_sign = 0; in_mant = 4'b1000; in_exp = 0; in_last = (i == 3);
      @(posedge clk); #1;
    end
    in_valid = 0; in_last = 0;
    expect_result("b2b", 128'h40000, 0);

    // Reset while draining discards the in-flight product.
    send(0, 8, 2, 0); send(0, 8, 0, 1);
    #2 rst = 1;
    #1;
    check("wait_rst_valid", out_valid, 0);
    check("wait_rst_acc", out_acc, 0);
    check("wait_rst_ovf", out_overflow, 0);
    #2 rst = 0;
    send(0, 8, 0, 1);
    expect_result("after_wait_rst", 128'h10000, 0);

    // Reset while a flagged result is presented.
    out_ready = 0;
    send(0, 8, 8, 1);
    repeat (2) @(posedge clk);
    #1;
    check("out_state_valid", out_valid, 1);
    #2 rst = 1;
    #1;
    check("out_rst_valid", out_valid, 0);
    check("out_rst_ovf", out_overflow, 0);
    check("out_rst_acc", out_acc, 0);
    #2 rst = 0;
    out_ready = 1;
    send(0, 8, 0, 1);
    expect_result("after_out_rst", 128'h10000, 0);

    // Tapered instance (NF 13, FR 24).
    tcase("t_one", 0, 8, 0, 128'(1) << FR_T, 0);
    tcase("t_top", 0, 8, 12, 128'(1) << (FR_T + 12), 0);
    tcase("t_ovf", 0, 8, 13, 128'h0, 1);
    tcase("t_lsb_neg", 1, 8, -24, {ACC_W_T{1'b1}}, 0);
    tcase("t_below", 0, 15, -28, 128'h0, 0);

    // Randomized traffic; heavy segments push same-sign large products to force wraps.
    for (int c = 0; c < 4000; c++) begin
      bit heavy;
      heavy     = ((c / 400) % 2) == 1;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = $urandom_range(0, 1) == 1;
      if (heavy) begin
        in_sign = ((c / 800) % 2) == 1;
        in_mant = 4'd15;
        in_exp  = 8'($urandom_range(6, 7));
        in_last = ($urandom_range(0, 63) == 0);
      end else begin
        in_sign = $urandom_range(0, 1) == 1;
        in_mant = 4'($urandom_range(0, 15));
        in_exp  = 8'(int'($urandom_range(0, 31)) - 22);
        in_last = ($urandom_range(0, 7) == 0);
      end
      @(posedge clk); #1;
    end
    in_valid = 0; in_last = 0; out_ready = 1;
    repeat (8) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
